// File: rtl/morse_pkg.sv
// Shared Morse timing definitions: FSM encodings and unit multipliers used by the
// keyer and the matching dot/dash decoder.
package morse_pkg;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] MARK     = 3'd1;
  localparam logic [2:0] SPACE    = 3'd2;
  localparam logic [2:0] CHAR_GAP = 3'd3;
  localparam logic [2:0] WORD_GAP = 3'd4;

  localparam int unsigned DOT_UNITS      = 1;
  localparam int unsigned DASH_UNITS     = 3;
  localparam int unsigned ELEM_GAP_UNITS = 1;
  localparam int unsigned CHAR_GAP_UNITS = 3;
  localparam int unsigned WORD_GAP_UNITS = 7;

  // Longest phase is the word gap, so it sets the duration counter width.
  function automatic int unsigned dur_cnt_width(input int unsigned unit_ticks);
    return $clog2(WORD_GAP_UNITS * unit_ticks + 1);
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Loadable down-counter; expired_o is high while the count sits at zero.
module morse_unit_timer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_TICKS = 4,
  parameter int unsigned CntW       = dur_cnt_width(UNIT_TICKS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  output logic            expired_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Saturates at zero rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/morse_code_tx.sv
// Morse keyer: takes one character pattern per handshake and plays it out as a timed
// key signal with dot/dash qualifiers and a done pulse.
module morse_code_tx
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_TICKS = 6_000_000,
  parameter int unsigned MAX_LEN    = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         sym_len,
  input  logic [MAX_LEN-1:0] sym_bits,
  output logic               key_out,
  output logic               dot_out,
  output logic               dash_out,
  output logic               done
);

  localparam int unsigned CntW = dur_cnt_width(UNIT_TICKS);

  function automatic logic [CntW-1:0] ticks(input int unsigned units);
    return CntW'(units * UNIT_TICKS - 1);
  endfunction

  logic [2:0]         state_q, state_d;
  logic [2:0]         elem_q, elem_d;
  logic [MAX_LEN-1:0] shift_q, shift_d;
  logic               key_q, key_d;
  logic               dot_q, dot_d;
  logic               dash_q, dash_d;
  logic               done_q, done_d;

  logic               tmr_load;
  logic [CntW-1:0]    tmr_val;
  logic               tmr_expired;
  logic [2:0]         len_clamped;

  assign in_ready    = (state_q == IDLE);
  assign len_clamped = (sym_len > 3'(MAX_LEN)) ? 3'(MAX_LEN) : sym_len;

  always_comb begin
    state_d  = state_q;
    elem_d   = elem_q;
    shift_d  = shift_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Left-align so the element being sent is always the MSB.
          shift_d  = sym_bits << (MAX_LEN - int'(len_clamped));
          elem_d   = len_clamped;
          tmr_load = 1'b1;
          if (len_clamped == 3'd0) begin
            state_d = WORD_GAP;
            tmr_val = ticks(WORD_GAP_UNITS);
          end else begin
            state_d = MARK;
            tmr_val = shift_d[MAX_LEN-1] ? ticks(DASH_UNITS) : ticks(DOT_UNITS);
          end
        end
      end
      MARK: begin
        if (tmr_expired) begin
          elem_d   = elem_q - 3'd1;
          tmr_load = 1'b1;
          if (elem_q == 3'd1) begin
            state_d = CHAR_GAP;
            tmr_val = ticks(CHAR_GAP_UNITS);
          end else begin
            state_d = SPACE;
            shift_d = shift_q << 1;
            tmr_val = ticks(ELEM_GAP_UNITS);
          end
        end
      end
      SPACE: begin
        if (tmr_expired) begin
          state_d  = MARK;
          tmr_load = 1'b1;
          tmr_val  = shift_q[MAX_LEN-1] ? ticks(DASH_UNITS) : ticks(DOT_UNITS);
        end
      end
      CHAR_GAP, WORD_GAP: begin
        if (tmr_expired) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs follow the next state so they line up with state_q after the edge.
  always_comb begin
    key_d  = (state_d == MARK);
    dot_d  = key_d & ~shift_d[MAX_LEN-1];
    dash_d = key_d & shift_d[MAX_LEN-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      elem_q  <= '0;
      shift_q <= '0;
      key_q   <= 1'b0;
      dot_q   <= 1'b0;
      dash_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      shift_q <= shift_d;
      key_q   <= key_d;
      dot_q   <= dot_d;
      dash_q  <= dash_d;
      done_q  <= done_d;
    end
  end

  morse_unit_timer #(
    .UNIT_TICKS (UNIT_TICKS),
    .CntW       (CntW)
  ) u_timer (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  assign key_out  = key_q;
  assign dot_out  = dot_q;
  assign dash_out = dash_q;
  assign done     = done_q;

endmodule

// File: tb/tb_morse_code_tx.sv
// Scoreboard bench for morse_code_tx: busy-period key runs and done pulses are
// compared against expected run lists queued when each request is issued.
module tb_morse_code_tx;

  localparam int unsigned UT = 4;
  localparam int unsigned ML = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    sym_len;
  logic [ML-1:0] sym_bits;
  logic          key_out;
  logic          dot_out;
  logic          dash_out;
  logic          done;

  int checks   = 0;
  int failures = 0;
  // Entry encoding: class*1000 + run length (0=low,1=dot,2=dash,3=illegal); -1 = done.
  int exp_q[$];
  int run_cls  = 0;
  int run_len  = 0;

  morse_code_tx #(
    .UNIT_TICKS (UT),
    .MAX_LEN    (ML)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sym_len  (sym_len),
    .sym_bits (sym_bits),
    .key_out  (key_out),
    .dot_out  (dot_out),
    .dash_out (dash_out),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_compare(input int obs);
    int e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard: got %0d expected nothing at %0t", obs, $time);
    end else begin
      e = exp_q.pop_front();
      if (e != obs) begin
        failures++;
        $display("FAIL scoreboard: got %0d expected %0d at %0t", obs, e, $time);
      end
    end
  endtask

  // Monitor: run-length encode the key while busy, pop on run end and on done.
  always @(negedge clk) begin
    int cls;
    if (!reset_n) begin
      run_len = 0;
    end else begin
      if (!key_out) cls = (dot_out || dash_out) ? 3 : 0;
      else if (dot_out && !dash_out) cls = 1;
      else if (dash_out && !dot_out) cls = 2;
      else cls = 3;
      if (run_len > 0 && (in_ready || cls != run_cls)) begin
        sb_compare(run_cls * 1000 + run_len);
        run_len = 0;
      end
      if (!in_ready) begin
        if (run_len == 0) run_cls = cls;
        run_len++;
      end
      if (done) sb_compare(-1);
    end
  end

  task automatic push_expect(input logic [2:0] len, input logic [ML-1:0] bits);
    int l;
    l = (len > 3'(ML)) ? ML : int'(len);
    if (l == 0) begin
      exp_q.push_back(7 * UT);
    end else begin
      for (int i = l - 1; i >= 0; i--) begin
        exp_q.push_back(bits[i] ? 2000 + 3 * UT : 1000 + UT);
        if (i > 0) exp_q.push_back(UT);
      end
      exp_q.push_back(3 * UT);
    end
    exp_q.push_back(-1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [2:0] len, input logic [ML-1:0] bits);
    @(negedge clk);
    wait_ready();
    push_expect(len, bits);
    sym_len  = len;
    sym_bits = bits;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int stray;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    sym_len  = '0;
    sym_bits = '0;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_key", int'(key_out), 0);
    chk("rst_dot", int'(dot_out), 0);
    chk("rst_dash", int'(dash_out), 0);
    chk("rst_done", int'(done), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    send(3'd1, 5'b00000);  // E
    wait_done(100);
    send(3'd2, 5'b00001);  // A
    wait_done(200);
    send(3'd0, 5'b10101);  // word gap
    wait_done(200);
    send(3'd7, 5'b11111);  // clamps to five dashes
    wait_done(400);

    // T then E held on in_valid: E must wait for T's done cycle.
    @(negedge clk);
    wait_ready();
    push_expect(3'd1, 5'b00001);
    push_expect(3'd1, 5'b00000);
    sym_len  = 3'd1;
    sym_bits = 5'b00001;
    in_valid = 1'b1;
    @(negedge clk);
    sym_bits = 5'b00000;
    wait_done(200);
    @(negedge clk);
    chk("b2b_key", int'(key_out), 1);
    chk("b2b_dot", int'(dot_out), 1);
    in_valid = 1'b0;
    wait_done(200);

    // Reset in the 6th cycle of a dash.
    send(3'd1, 5'b00001);
    repeat (5) @(negedge clk);
    chk("pre_rst_dash", int'(dash_out), 1);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_key", int'(key_out), 0);
    chk("async_dash", int'(dash_out), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", int'(in_ready), 1);
    chk("post_rst_done", int'(done), 0);
    stray = 0;
    repeat (30) begin
      @(negedge clk);
      if (key_out || dot_out || dash_out || done || !in_ready) stray++;
    end
    chk("post_rst_quiet", stray, 0);

    chk("sb_leftover", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
